// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong write sequencer: streams generator words into BRAM port A, one half at a time,
// and hands each full half to software through a ready/ack flag pair.
module bram_pingpong_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16384
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [1:0]            half_ready,
    input  logic [1:0]            half_ack,
    output logic                  overflow,
    output logic [31:0]           half_count
);

    localparam int unsigned HALF_WORDS = DEPTH / 2;
    localparam int unsigned IDX_W      = $clog2(HALF_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    cur_half_q, cur_half_d;
    logic [1:0]              set_pend_q, set_pend_d;
    logic [1:0]              half_ready_q, half_ready_d;
    logic                    overflow_q, overflow_d;
    logic [31:0]             half_count_q, half_count_d;
    logic                    enable_q;
    logic                    bram_en_q, bram_en_d;
    logic [3:0]              bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0]   bram_din_q, bram_din_d;

    logic                    accept;
    logic                    en_rise;
    logic                    new_half;
    logic [31:0]             byte_addr;

    assign s_ready   = enable && (state_q == ST_FILL);
    assign accept    = s_valid && s_ready;
    assign en_rise   = enable && !enable_q;
    assign new_half  = !cur_half_q;
    assign byte_addr = 32'({cur_half_q, idx_q}) << 2;

    // Next-state: a finished half is flagged one edge after its last write is registered,
    // so software never sees ready before the BRAM has captured the data.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cur_half_d   = cur_half_q;
        set_pend_d   = 2'b00;
        half_ready_d = (half_ready_q & ~half_ack) | set_pend_q;
        overflow_d   = en_rise ? 1'b0 : (overflow_q || (s_valid && !s_ready && enable));
        half_count_d = en_rise ? 32'd0 : half_count_q;
        bram_en_d    = accept;
        bram_we_d    = accept ? 4'hF : 4'h0;
        bram_addr_d  = accept ? ADDR_WIDTH'(byte_addr) : bram_addr_q;
        bram_din_d   = accept ? s_data : bram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_FILL;
                    idx_d      = '0;
                    cur_half_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d                  = '0;
                        set_pend_d[cur_half_q] = 1'b1;
                        half_count_d           = half_count_q + 32'd1;
                        cur_half_d             = new_half;
                        // A same-cycle ack on the other half frees it in time to keep filling.
                        if ((half_ready_q[new_half] && !half_ack[new_half]) || set_pend_q[new_half]) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!half_ready_q[cur_half_q] && !set_pend_q[cur_half_q]) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            cur_half_d   = 1'b0;
            set_pend_d   = 2'b00;
            half_ready_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cur_half_q   <= 1'b0;
            set_pend_q   <= 2'b00;
            half_ready_q <= 2'b00;
            overflow_q   <= 1'b0;
            half_count_q <= 32'd0;
            enable_q     <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 4'h0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cur_half_q   <= cur_half_d;
            set_pend_q   <= set_pend_d;
            half_ready_q <= half_ready_d;
            overflow_q   <= overflow_d;
            half_count_q <= half_count_d;
            enable_q     <= enable;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
        end
    end

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign half_ready = half_ready_q;
    assign overflow   = overflow_q;
    assign half_count = half_count_q;

endmodule

// File: doc/bram_pingpong_ctrl.md
# bram_pingpong_ctrl

Write-side controller that sequences the acquisition data generator into the shared simple dual-port sample BRAM. It treats the memory as two halves (ping-pong). It fills one half through BRAM port A while the processor drains the other half over AXI through port B, and hands each full half to software with a ready/acknowledge flag pair. It sits between the data generator stream and BRAM port A; its status and ack pins connect to the AXI register block.

## Interface
- ADDR_WIDTH, 16: BRAM byte-address width.
- DATA_WIDTH, 32: sample word width.
- DEPTH, 16384: BRAM depth in words. Must be even and a power of two. HALF_WORDS = DEPTH/2.
- clk  in  1  single clock for all logic, shared with BRAM port A.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level. 1 = run; 0 = stop and discard the partial half.
- s_valid  in  1  generator word valid.
- s_data  in  DATA_WIDTH  generator word.
- s_ready  out  1  controller can accept a word this cycle.
- bram_en  out  1  port A enable.
- bram_we  out  4  port A byte write enables: 4'hF on a write, else 0.
- bram_addr  out  ADDR_WIDTH  port A byte address, word aligned.
- bram_din  out  DATA_WIDTH  port A write data.
- half_ready  out  2  bit h = half h is full and owned by software.
- half_ack  in  2  single-cycle pulse from software: half h is drained.
- overflow  out  1  sticky: a word was offered while s_ready was 0.
- half_count  out  32  number of halves completed since enable rose (wraps).

## Operation
- States: IDLE, FILL (cur_half ∈ {0,1}), WAIT (cur_half is still owned by software).
- IDLE:
  - s_ready = 0.
  - When enable = 1, go to FILL with cur_half = 0 and word index = 0. The flags are all clear at this point.
- FILL:
  - s_ready = 1.
  - Each accepted word (s_valid & s_ready) writes to byte address (cur_half·HALF_WORDS + idx)·4, truncated to ADDR_WIDTH bits. Then idx increments.
  - When idx = HALF_WORDS−1 is accepted:
    - idx wraps to 0.
    - half_ready[cur_half] sets.
    - half_count increments.
    - cur_half toggles.
    - Next state is FILL if half_ready[new half] = 0 and no set is pending on it; otherwise next state is WAIT.
- WAIT:
  - s_ready = 0.
  - Stay until half_ready[cur_half] clears, then go to FILL.
- Ack handling:
  - half_ack[h] while half_ready[h] = 1 clears the bit on the next edge.
  - An ack on a bit that is already 0 is ignored.
  - Acks for both halves in the same cycle are both honoured.
- Overflow:
  - overflow sets on any cycle with s_valid = 1, s_ready = 0 and enable = 1.
  - It clears only on reset or on the rising edge of enable.
- Stopping:
  - enable = 0 from any state returns to IDLE on the next edge.
  - A write already registered still completes.
  - The partial half is discarded: idx, cur_half and half_ready are cleared.
  - half_count and overflow hold their values until the next enable rise, which zeroes half_count.
- The controller never reads BRAM; port A dout is unused.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - State IDLE, idx = 0, cur_half = 0.
  - s_ready = 0, bram_en = 0, bram_we = 0, bram_addr = 0, bram_din = 0.
  - half_ready = 2'b00, overflow = 0, half_count = 0.
- s_ready is a combinational decode of the state register and enable. It drops in the same cycle enable falls.
- Write latency:
  - A word accepted at edge N is presented on bram_en/we/addr/din during cycle N+1 (registered), and the BRAM captures it at edge N+2.
  - The bram_* outputs return to en = 0, we = 0 in the cycle after a write unless another word was accepted. addr and din hold their last values.
- Ready timing:
  - half_ready[h] rises one cycle after the last word's write strobe, at edge N+2 for a last word accepted at edge N.
  - Software therefore never sees ready before the data is stored.
- Throughput: one word per cycle sustained in FILL.
- WAIT exit:
  - An ack at edge M clears the ready bit at M+1.
  - The state becomes FILL at M+2, and s_ready = 1 in cycle M+2.
- Same-cycle events:
  - If the last word completes half h while half_ack[h^1] clears the other half, the ack wins. The controller proceeds directly to FILL with no WAIT cycle.
- Reset asserted mid-write aborts the write: bram_en drops immediately.

## Test plan
- DEPTH = 16, continuous s_valid, data = index, software acks each half 2 cycles after its ready rises:
  - Addresses run 0x00..0x3C and wrap.
  - half_ready pulses alternate 01, 10.
  - half_count = 4 after 32 words.
  - overflow = 0.
- DEPTH = 16, no acks:
  - After 16 words both half_ready bits = 1, the state is WAIT and s_ready = 0.
  - A further s_valid sets overflow.
  - half_ack = 2'b01 at edge M gives s_ready = 1 at cycle M+2, and the next write goes to addr 0x00.
- Ack on a not-ready half (half_ack = 2'b10 with half_ready = 2'b00): no change to any flag or state.
- enable dropped after 5 words of half 1:
  - Next cycle the state is IDLE, half_ready = 00, and s_ready = 0 in the same cycle enable falls.
  - Re-enable: the first write is to addr 0x00 and half_count = 0.
- Last word of half 0 accepted in the same cycle as half_ack[1] clears half 1: no WAIT cycle, and the next word writes to addr 0x20 (DEPTH = 16).
- rst_n pulsed low mid-FILL with bram_en = 1: all outputs go to their reset values asynchronously, before the next clock edge.
